// File: rtl/key_tick_control.sv
// Pushbutton front end for the DE1 BCD up/down counter: synchronise, debounce,
// derive run/direction/clear controls, and generate the 1 s count tick.
//
// state       | meaning
// RELEASED    | key up, waiting for a synchronised low
// PRESS_CHK   | key low, counting stable cycles before accepting the press
// PRESSED     | press accepted, held asserted
// RELEASE_CHK | key high, counting stable cycles before accepting the release
module key_tick_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic [2:0] press_pulse,
    output logic [2:0] held,
    output logic       enable,
    output logic       select,
    output logic       clear_pulse,
    output logic       tick
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    localparam logic [1:0] S_RELEASED    = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [1:0]       state_q [3];
    logic [1:0]       state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       press_q, press_d;
    logic [2:0]       held_q, held_d;
    logic             enable_q, enable_d;
    logic             select_q, select_d;
    logic             clear_q, clear_d;
    logic             tick_q, tick_d;
    logic [PRE_W-1:0] presc_q, presc_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // sync2_q is active-low: 0 means the key is seen pressed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = '0;
        held_d  = held_q;
        for (int i = 0; i < 3; i++) begin
            case (state_q[i])
                S_RELEASED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_PRESSED;
                        press_d[i] = 1'b1;
                        held_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                S_RELEASE_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_RELEASED;
                        held_d[i]  = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = S_RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // A clear restarts the prescaler and suppresses a coincident wrap tick
    always_comb begin
        enable_d = enable_q ^ press_d[0];
        select_d = select_q ^ press_d[1];
        clear_d  = press_d[2];
        tick_d   = (presc_q == PRE_LAST) && !press_d[2];
        if (press_d[2] || (presc_q == PRE_LAST)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 3'b111;
            sync2_q  <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= S_RELEASED;
                cnt_q[i]   <= '0;
            end
            press_q  <= '0;
            held_q   <= '0;
            enable_q <= 1'b0;
            select_q <= 1'b0;
            clear_q  <= 1'b0;
            tick_q   <= 1'b0;
            presc_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            held_q   <= held_d;
            enable_q <= enable_d;
            select_q <= select_d;
            clear_q  <= clear_d;
            tick_q   <= tick_d;
            presc_q  <= presc_d;
        end
    end

    assign press_pulse = press_q;
    assign held        = held_q;
    assign enable      = enable_q;
    assign select      = select_q;
    assign clear_pulse = clear_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_key_tick_control.sv
// Scoreboard bench for key_tick_control: a run-length debounce model and a
// tick schedule predict events, a negedge monitor matches the DUT against them.
module tb_key_tick_control;

    localparam int DEB  = 4;
    localparam int TICK = 10;

    logic       clk_sys;
    logic       reset;
    logic [2:0] key_n;
    logic [2:0] press_pulse;
    logic [2:0] held;
    logic       enable;
    logic       select;
    logic       clear_pulse;
    logic       tick;

    key_tick_control #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TICK)
    ) dut (
        .CLOCK_50   (clk_sys),
        .reset      (reset),
        .key_n      (key_n),
        .press_pulse(press_pulse),
        .held       (held),
        .enable     (enable),
        .select     (select),
        .clear_pulse(clear_pulse),
        .tick       (tick)
    );

    typedef struct {
        int         cyc;
        logic [2:0] pat;
    } ev_t;

    ev_t  press_q[$];
    int   tick_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 0;

    // reference model state
    logic [2:0] q1 = 3'b111;
    logic [2:0] q2 = 3'b111;
    logic [2:0] m_held = '0;
    logic [2:0] m_pulse = '0;
    logic       m_en = 1'b0;
    logic       m_sel = 1'b0;
    logic       m_tick = 1'b0;
    int         run[3];
    int         next_tick = 0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // A key's debounced level flips once DEB+1 consecutive synchronised samples
    // disagree with it; a tick is due TICK edges after the last wrap or clear.
    initial begin
        logic [2:0] s_seen;
        logic [2:0] pulse;
        forever begin
            @(posedge clk_sys);
            cyc++;
            if (!reset) begin
                q1 = 3'b111;
                q2 = 3'b111;
                m_held = '0;
                m_pulse = '0;
                m_en = 1'b0;
                m_sel = 1'b0;
                m_tick = 1'b0;
                for (int i = 0; i < 3; i++) run[i] = 0;
                next_tick = cyc + TICK;
            end else begin
                s_seen = q2;
                q2 = q1;
                q1 = key_n;
                pulse = '0;
                for (int i = 0; i < 3; i++) begin
                    if ((!s_seen[i]) != m_held[i]) begin
                        run[i]++;
                        if (run[i] == DEB + 1) begin
                            m_held[i] = ~m_held[i];
                            run[i] = 0;
                            if (m_held[i]) pulse[i] = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                m_en = m_en ^ pulse[0];
                m_sel = m_sel ^ pulse[1];
                m_tick = 1'b0;
                if (pulse[2]) begin
                    next_tick = cyc + TICK;
                end else if (cyc == next_tick) begin
                    m_tick = 1'b1;
                    next_tick = cyc + TICK;
                end
                m_pulse = pulse;
                if (pulse != 3'b000) press_q.push_back('{cyc, pulse});
                if (m_tick) tick_q.push_back(cyc);
            end
        end
    end

    initial begin
        ev_t ev;
        int  tc;
        forever begin
            @(negedge clk_sys);
            if (mon_on) begin
                while (press_q.size() > 0 && press_q[0].cyc < cyc) begin
                    ev = press_q.pop_front();
                    checks++; errors++;
                    $display("FAIL press_missed exp_cyc=%0d exp=%b now=%0d", ev.cyc, ev.pat, cyc);
                end
                while (tick_q.size() > 0 && tick_q[0] < cyc) begin
                    tc = tick_q.pop_front();
                    checks++; errors++;
                    $display("FAIL tick_missed exp_cyc=%0d now=%0d", tc, cyc);
                end
                if (press_pulse != 3'b000 || (press_q.size() > 0 && press_q[0].cyc == cyc)) begin
                    checks++;
                    if (press_q.size() == 0) begin
                        errors++;
                        $display("FAIL press_unexpected cyc=%0d got=%b exp=none", cyc, press_pulse);
                    end else begin
                        ev = press_q.pop_front();
                        if (ev.cyc != cyc || ev.pat !== press_pulse) begin
                            errors++;
                            $display("FAIL press_evt cyc=%0d got=%b exp=%b exp_cyc=%0d",
                                     cyc, press_pulse, ev.pat, ev.cyc);
                        end
                    end
                end
                if (tick || (tick_q.size() > 0 && tick_q[0] == cyc)) begin
                    checks++;
                    if (tick_q.size() == 0) begin
                        errors++;
                        $display("FAIL tick_unexpected cyc=%0d got=%b exp=none", cyc, tick);
                    end else begin
                        tc = tick_q.pop_front();
                        if (tc != cyc || tick !== 1'b1) begin
                            errors++;
                            $display("FAIL tick_evt cyc=%0d got=%b exp_cyc=%0d", cyc, tick, tc);
                        end
                    end
                end
                checks++;
                if ({held, enable, select, clear_pulse} !== {m_held, m_en, m_sel, m_pulse[2]}) begin
                    errors++;
                    $display("FAIL levels cyc=%0d got held=%b en=%b sel=%b clr=%b exp held=%b en=%b sel=%b clr=%b",
                             cyc, held, enable, select, clear_pulse, m_held, m_en, m_sel, m_pulse[2]);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] k, input int n);
        key_n = k;
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        checks++;
        if ({press_pulse, held, enable, select, clear_pulse, tick} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {press_pulse, held, enable, select, clear_pulse, tick});
        end
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        key_n = 3'b111;
        @(negedge clk_sys);
        #1;
        mon_on = 1'b1;
        do_reset(3);
        drive(3'b111, 25);
        // key 0 twice: enable 0 -> 1 -> 0
        drive(3'b110, 10); drive(3'b111, 8);
        drive(3'b110, 10); drive(3'b111, 8);
        // key 1 short glitch rejected, then a long enough press
        drive(3'b101, 3);  drive(3'b111, 8);
        drive(3'b101, 6);  drive(3'b111, 8);
        // key 2 long hold with bouncing release
        drive(3'b011, 50);
        drive(3'b111, 2); drive(3'b011, 2); drive(3'b111, 2); drive(3'b011, 2);
        drive(3'b111, 20);
        // keys 0 and 2 on the same edge
        drive(3'b010, 10); drive(3'b111, 15);
        // reset in the middle of a press check, key still held afterwards
        drive(3'b110, 4);
        do_reset(3);
        drive(3'b110, 15); drive(3'b111, 12);
        // randomised key activity
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
            drive(3'($urandom_range(0, 7)), $urandom_range(1, 9));
        end
        drive(3'b111, 30);
        checks++;
        if (press_q.size() != 0 || tick_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got press=%0d tick=%0d exp=0", press_q.size(), tick_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
